// File: rtl/pc_control_pkg.sv
// Shared constants for the next-PC selection block: condition codes,
// control-flow kinds and flag register bit positions.
package pc_control_pkg;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_UN = 3'b111;

    localparam logic [1:0] BT_B   = 2'b00;
    localparam logic [1:0] BT_BR  = 2'b01;
    localparam logic [1:0] BT_PCS = 2'b10;
    localparam logic [1:0] BT_HLT = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

endpackage

// File: rtl/pc_control_if.sv
// Branch-control bus between decode/fetch and pc_control.
// With PC_CONTROL_TAKEN_CNT_EN defined it also carries TakenCount.
interface pc_control_if;

    logic        Branch;
    logic [1:0]  BranchType;
    logic [2:0]  C;
    logic [8:0]  I;
    logic [2:0]  F;
    logic [15:0] Reg;
    logic [15:0] PC_In;
    logic [15:0] PC_Out;
    logic        Taken;
    logic        Halted;
`ifdef PC_CONTROL_TAKEN_CNT_EN
    logic [15:0] TakenCount;
`endif

    modport master (
        output Branch, BranchType, C, I, F, Reg, PC_In,
`ifdef PC_CONTROL_TAKEN_CNT_EN
        input  TakenCount,
`endif
        input  PC_Out, Taken, Halted
    );

    modport slave (
        input  Branch, BranchType, C, I, F, Reg, PC_In,
`ifdef PC_CONTROL_TAKEN_CNT_EN
        output TakenCount,
`endif
        output PC_Out, Taken, Halted
    );

endinterface

// File: rtl/pc_cond_eval.sv
// Evaluates the 3-bit branch condition code against the {N, V, Z} flags.
module pc_cond_eval
    import pc_control_pkg::*;
(
    input  logic [2:0] C,
    input  logic [2:0] F,
    output logic       cond
);

    logic n, v, z;

    assign n = F[FLAG_N];
    assign v = F[FLAG_V];
    assign z = F[FLAG_Z];

    always_comb begin
        // NOTE: default first so every path assigns cond and no latch is inferred.
        cond = 1'b0;
        case (C)
            CC_NE:   cond = ~z;
            CC_EQ:   cond = z;
            CC_GT:   cond = ~z & ~n;
            CC_LT:   cond = n;
            CC_GE:   cond = z | (~z & ~n);
            CC_LE:   cond = n | z;
            CC_OV:   cond = v;
            CC_UN:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// Combinational next-PC selection with a sticky registered halt flag.
// Defining PC_CONTROL_TAKEN_CNT_EN adds a saturating taken-branch counter.
module pc_control
    import pc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    pc_control_if.slave bus
);

    logic [15:0] pc_plus2;
    logic [15:0] target;
    logic [15:0] pc_next;
    logic        cond;
    logic        taken;
    logic        halted;

    pc_cond_eval u_cond_eval (
        .C    (bus.C),
        .F    (bus.F),
        .cond (cond)
    );

    // Offset is in words: sign-extend the 9-bit immediate and shift left once.
    assign pc_plus2 = bus.PC_In + 16'd2;
    assign target   = pc_plus2 + {{6{bus.I[8]}}, bus.I, 1'b0};

    always_comb begin
        pc_next = pc_plus2;
        taken   = 1'b0;
        if (bus.Branch) begin
            case (bus.BranchType)
                BT_B: begin
                    taken = cond;
                    if (cond) pc_next = target;
                end
                BT_BR: begin
                    taken = cond;
                    if (cond) pc_next = bus.Reg;
                end
                BT_PCS:  pc_next = pc_plus2;
                BT_HLT:  pc_next = bus.PC_In;
                default: pc_next = pc_plus2;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halted <= 1'b0;
        // NOTE: non-blocking assignment keeps register updates race-free with other clocked logic.
        else if (bus.Branch && bus.BranchType == BT_HLT)
            halted <= 1'b1;
    end

    assign bus.PC_Out = pc_next;
    assign bus.Taken  = taken;
    assign bus.Halted = halted;

`ifdef PC_CONTROL_TAKEN_CNT_EN
    logic [15:0] taken_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            taken_count <= 16'd0;
        else if (taken && !halted && taken_count != 16'hFFFF)
            taken_count <= taken_count + 16'd1;
    end

    assign bus.TakenCount = taken_count;
`endif

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed plan vectors plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_pc_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pc_control_if bus ();

    pc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: sticky halt and (optionally) the taken counter.
    bit m_halted = 1'b0;
    int m_cnt = 0;

    function automatic bit model_cond(input logic [2:0] c, input logic [2:0] f);
        bit n = f[2];
        bit v = f[1];
        bit z = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_taken();
        if (!bus.Branch) return 1'b0;
        if (bus.BranchType > 2'd1) return 1'b0;
        return model_cond(bus.C, bus.F);
    endfunction

    function automatic int model_pc();
        int pc     = int'(bus.PC_In);
        int seq    = (pc + 2) % 65536;
        int offset = (int'(bus.I) >= 256) ? int'(bus.I) - 512 : int'(bus.I);
        int tgt    = (pc + 2 + 2 * offset + 65536) % 65536;
        if (!bus.Branch) return seq;
        case (bus.BranchType)
            2'd0: return model_taken() ? tgt : seq;
            2'd1: return model_taken() ? int'(bus.Reg) : seq;
            2'd2: return seq;
            default: return pc;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_halted <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if (model_taken() && !m_halted && m_cnt < 65535)
                m_cnt <= m_cnt + 1;
            if (bus.Branch && bus.BranchType == 2'd3)
                m_halted <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc_out", {16'd0, bus.PC_Out}, model_pc());
            check("model_taken", {31'd0, bus.Taken}, {31'd0, model_taken()});
            check("model_halted", {31'd0, bus.Halted}, {31'd0, m_halted});
`ifdef PC_CONTROL_TAKEN_CNT_EN
            check("model_taken_count", {16'd0, bus.TakenCount}, m_cnt);
`endif
        end
    end

    task automatic drive(input logic br, input logic [1:0] bt, input logic [2:0] c,
                         input logic [8:0] i, input logic [2:0] f,
                         input logic [15:0] r, input logic [15:0] pc);
        @(posedge clk);
        #1;
        bus.Branch = br;
        bus.BranchType = bt;
        bus.C = c;
        bus.I = i;
        bus.F = f;
        bus.Reg = r;
        bus.PC_In = pc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.Branch = 1'b0;
        bus.BranchType = 2'd0;
        bus.C = 3'd0;
        bus.I = 9'd0;
        bus.F = 3'd0;
        bus.Reg = 16'd0;
        bus.PC_In = 16'd0;

        #2 rst = 1'b1;
        #1 check("reset_halted", {31'd0, bus.Halted}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        drive(1'b0, 2'b00, 3'b000, 9'd0, 3'b000, 16'h0000, 16'd2);
        check("seq_pc", {16'd0, bus.PC_Out}, 32'd4);
        check("seq_taken", {31'd0, bus.Taken}, 32'd0);

        drive(1'b1, 2'b00, 3'b001, 9'd3, 3'b001, 16'h0000, 16'd4);
        check("b_eq_pc", {16'd0, bus.PC_Out}, 32'd12);
        check("b_eq_taken", {31'd0, bus.Taken}, 32'd1);

        drive(1'b1, 2'b01, 3'b010, 9'd0, 3'b000, 16'h00FE, 16'd6);
        check("br_gt_pc", {16'd0, bus.PC_Out}, 32'h00FE);
        drive(1'b1, 2'b01, 3'b111, 9'd0, 3'b101, 16'h000A, 16'd6);
        check("br_un_pc", {16'd0, bus.PC_Out}, 32'h000A);

        drive(1'b1, 2'b00, 3'b011, 9'd3, 3'b001, 16'h0000, 16'd14);
        check("b_lt_nt_pc", {16'd0, bus.PC_Out}, 32'd16);
        check("b_lt_nt_taken", {31'd0, bus.Taken}, 32'd0);
        drive(1'b1, 2'b00, 3'b111, 9'h1FE, 3'b000, 16'h0000, 16'h0020);
        check("b_neg_pc", {16'd0, bus.PC_Out}, 32'h001E);

        drive(1'b1, 2'b10, 3'b111, 9'd3, 3'b000, 16'h0000, 16'd8);
        check("pcs_pc", {16'd0, bus.PC_Out}, 32'd10);
        check("pcs_taken", {31'd0, bus.Taken}, 32'd0);

        drive(1'b1, 2'b11, 3'b101, 9'd0, 3'b111, 16'h0000, 16'd12);
        check("hlt_pc", {16'd0, bus.PC_Out}, 32'd12);
        check("hlt_taken", {31'd0, bus.Taken}, 32'd0);
        drive(1'b0, 2'b00, 3'b000, 9'd0, 3'b000, 16'h0000, 16'd12);
        check("hlt_sticky", {31'd0, bus.Halted}, 32'd1);

        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_rst_halted", {31'd0, bus.Halted}, 32'd0);
        rst = 1'b0;

        drive(1'b0, 2'b00, 3'b000, 9'd0, 3'b000, 16'h0000, 16'hFFFE);
        check("wrap_pc", {16'd0, bus.PC_Out}, 32'd0);

        for (int k = 0; k < 600; k++) begin
            logic [1:0]  bt;
            logic [15:0] pc;
            bt = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) bt = 2'd3;
            pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE - 16'($urandom_range(0, 3)) * 16'd2
                                             : 16'($urandom);
            drive(1'($urandom), bt, 3'($urandom), 9'($urandom), 3'($urandom),
                  16'($urandom), pc);
            if (m_halted && $urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
